// File: rtl/fwd_pkg.sv
// Shared types and select encodings for the forwarding/hazard controller.
// Pure definitions: no latency, no backpressure.
package fwd_pkg;

    localparam int HZ_AW = 4;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic [HZ_AW-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } hz_stage_t;

    localparam hz_stage_t HZ_BUBBLE = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding priority compare; purely combinational.
// No backpressure: caller decides when the result is registered.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int REG_AW = HZ_AW
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic [REG_AW-1:0] near_rd_i,
    input  logic              near_wr_i,
    input  logic [REG_AW-1:0] far_rd_i,
    input  logic              far_wr_i,
    output logic [1:0]        sel_o
);

    // The nearer producer holds the younger value, so it takes priority.
    always_comb begin
        sel_o = FWD_IDEX;
        if (rs_used_i) begin
            if (near_wr_i && (near_rd_i == rs_i)) begin
                sel_o = FWD_EXMEM;
            end else if (far_wr_i && (far_rd_i == rs_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects (1-edge latency, registered) and combinational load-use stall.
// hold freezes all state; stall/flush insert a bubble into the shadow ID/EX stage.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = HZ_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    hz_stage_t        idex_q, exmem_q, memwb_q;
    hz_stage_t        idex_d, id_ent;
    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs1_hit, rs2_hit, kill;

    assign id_ent = '{rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    fwd_src_sel #(.REG_AW(REG_AW)) u_sel_a (
        .rs_i      (id_rs1),
        .rs_used_i (id_rs1_used),
        .near_rd_i (idex_q.rd),
        .near_wr_i (idex_q.reg_write),
        .far_rd_i  (exmem_q.rd),
        .far_wr_i  (exmem_q.reg_write),
        .sel_o     (sel_a)
    );

    fwd_src_sel #(.REG_AW(REG_AW)) u_sel_b (
        .rs_i      (id_rs2),
        .rs_used_i (id_rs2_used),
        .near_rd_i (idex_q.rd),
        .near_wr_i (idex_q.reg_write),
        .far_rd_i  (exmem_q.rd),
        .far_wr_i  (exmem_q.reg_write),
        .sel_o     (sel_b)
    );

    assign rs1_hit = id_rs1_used && (idex_q.rd == id_rs1);
    assign rs2_hit = id_rs2_used && (idex_q.rd == id_rs2);
    assign stall   = idex_q.mem_read && idex_q.reg_write && (rs1_hit || rs2_hit) && !flush;
    assign kill    = stall || flush;

    always_comb begin
        idex_d  = id_ent;
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
        cnt_d   = cnt_q;
        if (kill) begin
            idex_d  = HZ_BUBBLE;
            fwd_a_d = FWD_IDEX;
            fwd_b_d = FWD_IDEX;
        end
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= HZ_BUBBLE;
            exmem_q <= HZ_BUBBLE;
            memwb_q <= HZ_BUBBLE;
            fwd_a_q <= FWD_IDEX;
            fwd_b_q <= FWD_IDEX;
            cnt_q   <= '0;
        end else if (!hold) begin
            idex_q  <= idex_d;
            exmem_q <= idex_q;
            memwb_q <= exmem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB is tracked for pipeline visibility only; nothing is forwarded from it here.
    logic unused_memwb;
    assign unused_memwb = ^memwb_q;

    assign ForwardA    = fwd_a_q;
    assign ForwardB    = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed table, hand sequences, randomized run vs. reference model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, flush, hold;
    logic [1:0] ForwardA, ForwardB, fa_s, fb_s;
    logic       stall, st_s;
    logic [15:0] stall_count;
    logic [3:0]  cnt_s;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .stall(stall), .stall_count(stall_count)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    fwd_hazard_unit #(.REG_AW(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
        .ForwardA(fa_s), .ForwardB(fb_s), .stall(st_s), .stall_count(cnt_s)
    );

    typedef struct {
        int rs1, rs2, u1, u2, rd, wr, ld, fl, hd;
        int e_st, e_fa, e_fb, e_cnt;
    } vec_t;

    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: pipe[0] is the youngest in-flight instruction (ID/EX).
    ent_t pipe[$];
    int   m_st, m_fa, m_fb, m_cnt, m_cnt_s;
    int   a_st, a_st_s, a_fa, a_fb, a_cnt, a_fa_s, a_fb_s, a_cnt_s;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int rs1, rs2, u1, u2, rd, wr, ld, fl, hd,
                                input int st, fa, fb, cnt);
        vec_t v;
        v = '{rs1, rs2, u1, u2, rd, wr, ld, fl, hd, st, fa, fb, cnt};
        return v;
    endfunction

    function automatic void model_reset();
        ent_t b;
        b = '{0, 1'b0, 1'b0};
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(b);
        m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt_s = 0;
    endfunction

    // Select code = which older instruction produces rs: distance 1 -> 2, distance 2 -> 1.
    function automatic int model_sel(input int rs, input int used);
        if (used == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wr && pipe[k].rd == rs) return (k == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic int model_stall();
        ent_t p;
        p = pipe[0];
        if (flush || !(p.ld && p.wr)) return 0;
        if (id_rs1_used && p.rd == int'(id_rs1)) return 1;
        if (id_rs2_used && p.rd == int'(id_rs2)) return 1;
        return 0;
    endfunction

    function automatic void model_edge();
        ent_t n;
        if (rst) begin
            model_reset();
            return;
        end
        if (hold) return;
        if (m_st != 0 || flush) begin
            n = '{0, 1'b0, 1'b0};
            m_fa = 0; m_fb = 0;
        end else begin
            n = '{int'(id_rd), id_reg_write, id_mem_read};
            m_fa = model_sel(int'(id_rs1), int'(id_rs1_used));
            m_fb = model_sel(int'(id_rs2), int'(id_rs2_used));
        end
        if (m_st != 0) begin
            m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_cnt_s = (m_cnt_s < 15) ? m_cnt_s + 1 : 15;
        end
        pipe.push_front(n);
        void'(pipe.pop_back());
    endfunction

    task automatic apply(input vec_t v, input logic r);
        id_rs1 = 4'(v.rs1); id_rs2 = 4'(v.rs2);
        id_rs1_used = v.u1[0]; id_rs2_used = v.u2[0];
        id_rd = 4'(v.rd); id_reg_write = v.wr[0]; id_mem_read = v.ld[0];
        flush = v.fl[0]; hold = v.hd[0]; rst = r;
        @(negedge clk);
        a_st = int'(stall); a_st_s = int'(st_s);
        m_st = model_stall();
        @(posedge clk);
        model_edge();
        #1;
        a_fa = int'(ForwardA); a_fb = int'(ForwardB); a_cnt = int'(stall_count);
        a_fa_s = int'(fa_s); a_fb_s = int'(fb_s); a_cnt_s = int'(cnt_s);
    endtask

    vec_t tbl[22];
    vec_t v;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(3, 0, 1, 0,  4, 1, 0, 0, 0,  0, 2, 0, 0);
        tbl[2]  = mk(7, 0, 1, 0,  6, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[3]  = mk(4, 0, 1, 0,  5, 1, 0, 0, 0,  0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(5, 5, 0, 1,  8, 1, 0, 0, 0,  0, 0, 2, 0);
        tbl[6]  = mk(8, 0, 1, 0,  2, 1, 1, 0, 0,  0, 2, 0, 0);
        tbl[7]  = mk(2, 0, 1, 0,  9, 1, 0, 0, 0,  1, 0, 0, 1);
        tbl[8]  = mk(2, 0, 1, 0,  9, 1, 0, 0, 0,  0, 1, 0, 1);
        tbl[9]  = mk(9, 2, 1, 1, 10, 1, 0, 0, 0,  0, 2, 0, 1);
        tbl[10] = mk(0, 0, 0, 0,  2, 1, 1, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(2, 0, 1, 0, 11, 1, 0, 1, 0,  0, 0, 0, 1);
        tbl[12] = mk(2, 0, 1, 0,  1, 1, 1, 0, 0,  0, 1, 0, 1);
        tbl[13] = mk(0, 1, 0, 1,  3, 1, 0, 0, 1,  1, 1, 0, 1);
        tbl[14] = mk(0, 1, 0, 1,  3, 1, 0, 0, 1,  1, 1, 0, 1);
        tbl[15] = mk(0, 1, 0, 1,  3, 1, 0, 0, 1,  1, 1, 0, 1);
        tbl[16] = mk(0, 1, 0, 1,  3, 1, 0, 0, 0,  1, 0, 0, 2);
        tbl[17] = mk(0, 1, 0, 1,  3, 1, 0, 0, 0,  0, 0, 1, 2);
        tbl[18] = mk(0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 2);
        tbl[19] = mk(0, 3, 1, 1,  4, 1, 0, 0, 0,  0, 2, 1, 2);
        tbl[20] = mk(0, 0, 0, 0,  7, 1, 1, 0, 0,  0, 0, 0, 2);
        tbl[21] = mk(7, 7, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 2);

        model_reset();
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(v, 1'b1);
        apply(v, 1'b1);
        chk("reset_fwdA", a_fa, 0);
        chk("reset_fwdB", a_fb, 0);
        chk("reset_cnt", a_cnt, 0);
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], 1'b0);
            chk($sformatf("tbl%0d_stall", i), a_st, tbl[i].e_st);
            chk($sformatf("tbl%0d_fwdA", i), a_fa, tbl[i].e_fa);
            chk($sformatf("tbl%0d_fwdB", i), a_fb, tbl[i].e_fb);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].e_cnt);
        end

        // Reset asserted during a load-use stall.
        apply(mk(0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        v = mk(6, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(v, 1'b1);
        chk("rstmid_stall_before", a_st, 1);
        chk("rstmid_cnt", a_cnt, 0);
        chk("rstmid_fwdA", a_fa, 0);
        apply(v, 1'b0);
        chk("rstmid_stall_after", a_st, 0);
        chk("rstmid_fwdA_after", a_fa, 0);

        // Saturation: a dependent load chain stalls every other cycle.
        apply(v, 1'b1);
        v = mk(2, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 28; i++) apply(v, 1'b0);
        chk("sat_pre_small", a_cnt_s, 14);
        chk("sat_pre_main", a_cnt, 14);
        for (int i = 0; i < 6; i++) apply(v, 1'b0);
        chk("sat_small", a_cnt_s, 15);
        chk("sat_main", a_cnt, 17);

        for (int i = 0; i < 2000; i++) begin
            v.rs1 = $urandom_range(0, 3);  v.rs2 = $urandom_range(0, 3);
            v.u1  = $urandom_range(0, 1);  v.u2  = $urandom_range(0, 1);
            v.rd  = $urandom_range(0, 3);
            v.wr  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            v.ld  = ($urandom_range(0, 9) < 4) ? 1 : 0;
            v.fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            v.hd  = ($urandom_range(0, 6) == 0) ? 1 : 0;
            apply(v, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            chk("rnd_stall", a_st, m_st);
            chk("rnd_stall_s", a_st_s, m_st);
            chk("rnd_fwdA", a_fa, m_fa);
            chk("rnd_fwdB", a_fb, m_fb);
            chk("rnd_fwdA_s", a_fa_s, m_fa);
            chk("rnd_fwdB_s", a_fb_s, m_fb);
            chk("rnd_cnt", a_cnt, m_cnt);
            chk("rnd_cnt_s", a_cnt_s, m_cnt_s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 16-bit pipelined datapath. It tracks destination-register metadata through its own shadow ID/EX, EX/MEM and MEM/WB stages. It produces the registered 2-bit `ForwardA`/`ForwardB` selects consumed by the EX-stage operand muxes, and it raises a one-cycle stall on load-use dependencies. It sits beside the ID/EX pipeline register and drives the operand-mux selects, the PC/IF-ID hold, and a saturating stall-event counter.

## Interface
Parameters:
- `REG_AW`, 4: register-address width (16 architectural registers).
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_AW  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  source operand actually read.
- `id_rd`  in  REG_AW  destination of the ID instruction.
- `id_reg_write`  in  1  ID instruction writes `id_rd`.
- `id_mem_read`  in  1  ID instruction is a load.
- `flush`  in  1  kill the ID instruction (taken branch).
- `hold`  in  1  global freeze (memory wait).
- `ForwardA`, `ForwardB`  out  2  operand-A/B source select for the EX-stage instruction; registered.
- `stall`  out  1  hold PC and IF/ID this cycle; combinational.
- `stall_count`  out  CNT_W  number of stall cycles inserted; saturating.

## Operation
- Select encoding: 2'b00 = ID/EX register-file value; 2'b10 = EX/MEM ALU result; 2'b01 = MEM/WB result (DM or older ALU). 2'b11 is never driven.
- Shadow stages:
  - Each stage holds {rd, reg_write, mem_read}.
  - Each edge: MEM/WB <= EX/MEM, EX/MEM <= ID/EX, ID/EX <= ID inputs or a bubble.
  - A bubble is reg_write=0, mem_read=0.
- Next-select for operand X (rs1→A, rs2→B), evaluated against the current ID/EX and EX/MEM entries. These entries become EX/MEM and MEM/WB when the ID instruction reaches EX.
  - If not `id_rsX_used`: 00.
  - Else if ID/EX.reg_write and ID/EX.rd == id_rsX: 10. The nearer producer wins.
  - Else if EX/MEM.reg_write and EX/MEM.rd == id_rsX: 01.
  - Else: 00.
- Register 0 is an ordinary register and is forwarded like any other.
- Load-use: `stall` = ID/EX.mem_read & ID/EX.reg_write & ((rs1_used & ID/EX.rd == rs1) | (rs2_used & ID/EX.rd == rs2)) & !flush.
- When `stall` is asserted:
  - A bubble enters ID/EX and `ForwardA`/`ForwardB` load 00.
  - Upstream holds ID, so the same instruction is re-evaluated next cycle.
  - On re-evaluation the load is in EX/MEM, so the select resolves to 01.
- When `flush` is asserted: a bubble enters ID/EX and the selects load 00. `flush` overrides `stall`.
- When `hold` is asserted: all shadow stages, selects and `stall_count` freeze. `stall` is still driven combinationally.
- `stall_count`: +1 on each edge where `stall & !hold`, saturating at all-ones.

## Timing
- Reset: all shadow stages are bubbles. `ForwardA`/`ForwardB` = 00, `stall_count` = 0, so `stall` = 0.
- Reset has priority over `hold` and `flush`.
- Select latency: computed in the cycle the consumer is in ID and valid for the whole cycle it is in EX (1 edge).
- A load-use dependency costs exactly 1 stall cycle per load. A back-to-back second dependent instruction does not stall again.
- Asserting `rst` mid-stall clears the stall on the next edge, with no partial counter update.
- `hold` during a stall cycle does not double-count.

## Structure
- Shared package `fwd_pkg`:
  - `FWD_IDEX` = 2'b00, `FWD_EXMEM` = 2'b10, `FWD_MEMWB` = 2'b01.
  - Struct typedef `hz_stage_t` = {rd, reg_write, mem_read}.
  - Bubble constant `HZ_BUBBLE`.
- One sub-module `fwd_src_sel`: the per-operand priority compare, instantiated twice (A and B).
- Top level holds the shadow stages, the stall logic and the counter.

## Test plan
- Reset: hold `rst` 2 cycles -> `ForwardA`=`ForwardB`=00, `stall`=0, `stall_count`=0.
- ALU→ALU forwarding, distance 1: write R3, then `id_rs1`=3 next → `ForwardA`=10 in the consumer's EX cycle. Distance 2 (one independent instruction between): → 01.
- Double hit: R5 written by both the ID/EX and EX/MEM entries, consumer reads rs2=5 → `ForwardB`=10.
- Load-use: load R2, then consumer uses rs1=2 → `stall`=1 for exactly 1 cycle and bubble inserted. Then the consumer's `ForwardA`=01 and `stall_count`=1.
- Flush vs stall: load-use condition present with `flush`=1 → `stall`=0, selects 00, `stall_count` unchanged.
- `hold`: assert during a load-use stall for 3 cycles → selects and `stall_count` frozen. After release, exactly 1 stall is counted.
- Saturation: preload 0xFFFE stall events, then 3 more → `stall_count`=0xFFFF.
